// File: rtl/capture_reader_if.sv
// Capture read-out bus: sample RAM read port plus the valid/ready stream to the transmitter.
// master = capture_reader, slave = RAM/transmitter side.
`timescale 1ns/1ps
interface capture_reader_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_rd_en, mem_addr, tx_data, tx_valid,
    input  mem_rd_data, tx_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, tx_data, tx_valid,
    output mem_rd_data, tx_ready
  );
endinterface

// File: rtl/capture_reader.sv
// Walks the capture RAM once from a programmable start address (wrapping at DEPTH-1)
// and streams every sample to the transmitter over valid/ready.
`timescale 1ns/1ps
module capture_reader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  capture_reader_if.master  bus,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic              vld_p1;

  function automatic logic [ADDR_W-1:0] clamp_addr(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} >= DEPTH_EXT) return '0;
    return a;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr         <= '0;
      cnt          <= '0;
      vld_p1       <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      // p1: RAM data is valid the cycle after the read strobe
      vld_p1       <= bus.mem_rd_en;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr  <= clamp_addr(start_addr);
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= READ;
          end
        end
        READ: begin
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= addr;
          state        <= WAIT;
        end
        WAIT: begin
          if (vld_p1) begin
            bus.tx_data  <= bus.mem_rd_data;
            bus.tx_valid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_valid && bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            addr        <= next_addr(addr);
            if (cnt == LAST_CNT) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Issue the next read on the handshake edge to keep 3-cycle throughput.
              cnt          <= cnt + 1'b1;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= next_addr(addr);
              state        <= WAIT;
            end
          end
        end
        default: begin
          bus.tx_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader (DEPTH=8, ADDR_W=4): cycle table for start latency,
// then full passes covering wrap, stall, ignored starts, restart from DONE, clamp and reset abort.
`timescale 1ns/1ps
module tb_capture_reader;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              done;

  capture_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  capture_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr[2:0]];
  end

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] data_q[$];
  int                vld_cycles;
  initial vld_cycles = 0;
  always @(posedge clk) begin
    if (bus.mem_rd_en) addr_q.push_back(bus.mem_addr);
    if (bus.tx_valid && bus.tx_ready) data_q.push_back(bus.tx_data);
    if (bus.tx_valid) vld_cycles <= vld_cycles + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] sa);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_pass(input string nm, input int sa_eff, input int ba, input int bd);
    int          idx;
    logic [31:0] a;
    logic [31:0] d;
    check({nm, "_handshakes"}, 32'(data_q.size() - bd), 32'd8);
    check({nm, "_reads"}, 32'(addr_q.size() - ba), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      idx = (sa_eff + i) % DEPTH;
      a = (ba + i < addr_q.size()) ? 32'(addr_q[ba + i]) : 32'hDEAD;
      d = (bd + i < data_q.size()) ? 32'(data_q[bd + i]) : 32'hDEAD;
      check($sformatf("%s_addr%0d", nm, i), a, 32'(idx));
      check($sformatf("%s_data%0d", nm, i), d, 32'(ram[idx]));
    end
  endtask

  typedef struct {
    logic              start;
    logic [ADDR_W-1:0] sa;
    logic              rdy;
    logic              e_rd;
    logic [ADDR_W-1:0] e_addr;
    logic              e_vld;
    logic [DATA_W-1:0] e_data;
    logic              e_busy;
    logic              e_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ba;
    int bd;
    int vb;
    logic [DATA_W-1:0] held;

    // start at edge k: mem_rd_en after k+1, tx_valid after k+3, one stall cycle at vector 8
    vecs[0] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd1, 1'b1, 1'b0};

    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);
    reset_n      = 1'b0;
    start        = 1'b0;
    start_addr   = '0;
    bus.tx_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({bus.mem_rd_en, bus.mem_addr, bus.tx_valid, bus.tx_data, busy, done}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start        = vecs[i].start;
      start_addr   = vecs[i].sa;
      bus.tx_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            32'({bus.mem_rd_en, bus.mem_addr, bus.tx_valid, bus.tx_data, busy, done}),
            32'({vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_data,
                 vecs[i].e_busy, vecs[i].e_done}));
    end

    // Reset asserted while SEND holds a sample
    @(negedge clk);
    start        = 1'b0;
    bus.tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.tx_valid) break;
    end
    check("t1_in_send", 32'(bus.tx_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t1_async_clear",
          32'({bus.mem_rd_en, bus.mem_addr, bus.tx_valid, bus.tx_data, busy, done}), 32'd0);
    @(negedge clk);
    reset_n      = 1'b1;
    bus.tx_ready = 1'b1;
    vb = vld_cycles;
    repeat (10) @(posedge clk);
    #1;
    check("t1_no_valid_after", 32'(vld_cycles - vb), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Full pass from 0
    ba = addr_q.size();
    bd = data_q.size();
    pulse_start(4'd0);
    wait_done("t2");
    check_pass("t2", 0, ba, bd);

    // Wrap at DEPTH-1 with distinct RAM contents
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'((i * 3 + 5) % 16);
    ba = addr_q.size();
    bd = data_q.size();
    pulse_start(4'd6);
    wait_done("t3");
    check_pass("t3", 6, ba, bd);

    // Transmitter stall holds the sample and blocks RAM access
    @(negedge clk);
    bus.tx_ready = 1'b0;
    ba = addr_q.size();
    bd = data_q.size();
    pulse_start(4'd2);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.tx_valid) break;
    end
    check("t4_valid", 32'(bus.tx_valid), 32'd1);
    held = bus.tx_data;
    check("t4_first_data", 32'(held), 32'(ram[2]));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_hold%0d", c),
            32'({bus.tx_valid, bus.tx_data, bus.mem_rd_en}), 32'({1'b1, held, 1'b0}));
    end
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_resume", 32'({bus.mem_rd_en, bus.mem_addr, bus.tx_valid}), 32'({1'b1, 4'd3, 1'b0}));
    wait_done("t4");
    check_pass("t4", 2, ba, bd);

    // start during READ, WAIT and SEND is ignored
    ba = addr_q.size();
    bd = data_q.size();
    @(negedge clk);
    start      = 1'b1;
    start_addr = 4'd0;
    @(negedge clk);
    start_addr = 4'd3;
    @(negedge clk);
    @(negedge clk);
    start        = 1'b0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    bus.tx_ready = 1'b1;
    wait_done("t5a");
    check_pass("t5a", 0, ba, bd);

    // start in DONE re-arms from the new address
    ba = addr_q.size();
    bd = data_q.size();
    @(negedge clk);
    start      = 1'b1;
    start_addr = 4'd3;
    @(posedge clk);
    #1;
    check("t5_rearm", 32'({done, busy}), 32'({1'b0, 1'b1}));
    @(negedge clk);
    start = 1'b0;
    wait_done("t5b");
    check_pass("t5b", 3, ba, bd);

    // Out-of-range start address clamps to 0
    ba = addr_q.size();
    bd = data_q.size();
    pulse_start(4'd9);
    wait_done("t6");
    check_pass("t6", 0, ba, bd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
